// File: rtl/alu_seq.sv
// Handshaked ALU: one operation in flight, single-cycle logic/arith/shift ops
// or an iterative shift-add unsigned multiply, result held until consumed.
module alu_seq #(
  parameter int WIDTH  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             zero;
    logic             ovf;
  } res_t;

  localparam int             CW    = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] W_AMT = (WIDTH + 1)'(WIDTH);
  localparam int             MSB   = WIDTH - 1;

  state_t state, state_nx;
  res_t   res_q, res_alu, mul_res;

  logic [2*WIDTH-1:0] acc, acc_nx, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               accept, is_mul, last_bit;

  logic [WIDTH:0] sum, diff, shl_ext, shr_ext;
  logic           amt_big;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (opcode == 3'b111) && (MUL_EN != 0);
  assign last_bit  = (cnt == LAST);

  // Extended by one bit so the shifted-out bit lands at a fixed position:
  // shl carry sits at bit WIDTH, shr carry at bit 0.
  assign sum     = {1'b0, op1} + {1'b0, op2};
  assign diff    = {1'b0, op1} - {1'b0, op2};
  assign shl_ext = {1'b0, op1} << op2;
  assign shr_ext = {op1, 1'b0} >> op2;
  assign amt_big = ({1'b0, op2} >= W_AMT);

  always_comb begin
    res_alu = '0;
    case (opcode)
      3'b000: begin
        res_alu.y     = sum[WIDTH-1:0];
        res_alu.carry = sum[WIDTH];
        res_alu.ovf   = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      3'b001: begin
        res_alu.y     = diff[WIDTH-1:0];
        res_alu.carry = diff[WIDTH];
        res_alu.ovf   = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
      end
      3'b010: res_alu.y = op1 & op2;
      3'b011: res_alu.y = op1 | op2;
      3'b100: res_alu.y = op1 ^ op2;
      3'b101: if (!amt_big) begin
        res_alu.y     = shl_ext[WIDTH-1:0];
        res_alu.carry = shl_ext[WIDTH];
      end
      3'b110: if (!amt_big) begin
        res_alu.y     = shr_ext[WIDTH:1];
        res_alu.carry = shr_ext[0];
      end
      default: ; // opcode 111 without a multiplier returns all zeros
    endcase
    res_alu.zero = (res_alu.y == '0);
  end

  // One multiplier bit per MUL cycle; the multiplicand walks left.
  assign acc_nx = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    mul_res       = '0;
    mul_res.y     = acc_nx[WIDTH-1:0];
    mul_res.hi    = acc_nx[2*WIDTH-1:WIDTH];
    mul_res.carry = |acc_nx[2*WIDTH-1:WIDTH];
    mul_res.zero  = (acc_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, op1};
        mplier <= op2;
        cnt    <= '0;
      end else begin
        res_q <= res_alu;
      end
    end else if (state == MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_bit) res_q <= mul_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = is_mul ? MUL : DONE;
      MUL:     if (last_bit) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign y     = res_q.y;
  assign hi    = res_q.hi;
  assign carry = res_q.carry;
  assign zero  = res_q.zero;
  assign ovf   = res_q.ovf;

endmodule
